pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage RV32 core (F/D/E/M/W).
//  - Drives stall/flush into the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  - Selects operand forwarding for the EX stage.
//  - Sequences multi-cycle EX ops (mul/div) and data-memory wait states via an FSM.
//  - Keeps a stall-cycle performance counter.
// PARAMETERS
//  MC_TIMEOUT  64  max cycles in MC_BUSY before mc_err_o asserts; counter width is $clog2(MC_TIMEOUT+1)
//  CNT_W       32  width of stall_cnt_o
// PORTS
//  clk_i            in   1      core clock; all state updates on the rising edge
//  rst_i            in   1      asynchronous, active-low reset
//  rs1_addr_d       in   5      ID rs1 index
//  rs2_addr_d       in   5      ID rs2 index
//  rs1_addr_e       in   5      EX rs1 index
//  rs2_addr_e       in   5      EX rs2 index
//  rd_addr_e/_m/_w  in   5      destination index in EX/MEM/WB
//  reg_we_e/_m/_w   in   1      stage writes the register file
//  is_load_e        in   1      EX instruction is a load
//  branch_taken_e   in   1      EX resolved a taken branch/jump
//  mc_op_e          in   1      EX holds a multi-cycle op
//  mc_done_i        in   1      multi-cycle unit result valid (1-cycle pulse)
//  mem_req_m        in   1      MEM stage issues a data access
//  mem_ack_i        in   1      data memory completes the access this cycle
//  stall_f/_d/_e/_m out  1      hold PC / IF-ID / ID-EX / EX-MEM registers
//  flush_d/_ex/_m/_w out 1      insert a bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
//  fwd_a_sel        out  2      EX operand A: 00 regfile, 10 MEM result, 01 WB result
//  fwd_b_sel        out  2      EX operand B: same encoding as fwd_a_sel
//  mc_start_o       out  1      1-cycle start pulse to the multi-cycle unit
//  mc_err_o         out  1      sticky timeout flag
//  stall_cnt_o      out  CNT_W  count of cycles with stall_f=1
// BEHAVIOUR
//  Reset: FSM=IDLE, timeout count=0, mc_err_o=0, stall_cnt_o=0. All stall/flush outputs
//   and mc_start_o=0 while reset is asserted; no state leaves IDLE on the first edge after release.
//  Forwarding (combinational, independent of the FSM):
//   - MEM wins over WB.
//   - A match requires we=1, rd!=x0 and rd==rs.
//  Load-use (IDLE only): is_load_e & reg_we_e & rd_addr_e!=0 & rd_addr_e in {rs1_d, rs2_d}
//   -> stall_f=stall_d=1, flush_ex=1 for exactly 1 cycle.
//  Branch (IDLE only): branch_taken_e -> flush_d=flush_ex=1 for 1 cycle.
//   Branch overrides load-use: no stall is raised.
//  FSM states IDLE, MC_BUSY, MEM_WAIT. Priority when several apply: MEM_WAIT > MC_BUSY > branch > load-use.
//   IDLE -> MEM_WAIT: mem_req_m & ~mem_ack_i.
//   IDLE -> MC_BUSY: mc_op_e & ~branch_taken_e. mc_start_o pulses in that IDLE cycle.
//    A taken branch in the same cycle suppresses the start.
//   MC_BUSY: stall_f/_d/_e=1, flush_m=1, timeout count increments.
//    mc_done_i -> IDLE. Stalls drop in the done cycle, so the result advances to MEM on the next edge.
//    mem_req_m & ~mem_ack_i (older access) -> MEM_WAIT. The timeout count is kept; resume MC_BUSY after ack.
//    Timeout count == MC_TIMEOUT -> set mc_err_o and stay in MC_BUSY.
//   MEM_WAIT: stall_f/_d/_e/_m=1, flush_w=1.
//    On mem_ack_i, stalls drop in the ack cycle.
//    Next state: MC_BUSY if a multi-cycle op was pending, else IDLE.
//   mc_done_i while not in MC_BUSY: ignored.
//  mc_err_o clears only on reset.
//  stall_cnt_o saturates at all-ones; it does not wrap.
//  Reset asserted mid-operation: immediate return to reset values; in-flight multi-cycle/memory ops are abandoned.
// STRUCTURE
//  e10_pkg:
//   - localparams FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
//   - FSM state encodings CTRL_IDLE / CTRL_MC_BUSY / CTRL_MEM_WAIT (2-bit).
//  Sub-module fwd_unit: combinational forwarding for both operands.
//  FSM, hazard logic and counters live in this file.
// TESTING
//  1. rd_m=5, we_m=1, rs1_e=5; rd_w=5, we_w=1 -> fwd_a_sel=10. Same with rd=0 -> 00.
//  2. Load rd_e=7, rs2_d=7 -> one cycle of stall_f=stall_d=flush_ex=1, then 0.
//     Add branch_taken_e in the same cycle -> flush_d=flush_ex=1, stall_f=0.
//  3. mc_op_e, mc_done_i after 10 cycles -> one mc_start_o pulse; 10 cycles of stall_e=flush_m=1; stall_cnt_o += 10.
//  4. mem_req_m with ack delayed 3 cycles during MC_BUSY -> stall_m=1 for 3 cycles.
//     After ack the FSM returns to MC_BUSY; the timeout count is preserved.
//  5. MC_TIMEOUT=4, mc_done_i never -> mc_err_o=1 after 4 cycles; stays 1 until reset.
//  6. Assert rst_i=0 mid-MEM_WAIT -> all outputs 0 asynchronously; FSM IDLE after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned REG_AW = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      CTRL_IDLE     = 2'd0,
      CTRL_MC_BUSY  = 2'd1,
      CTRL_MEM_WAIT = 2'd2
   } ctrl_state_e;

   // Per-cycle stall/flush bundle, one bit per pipeline register
   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic flush_d;
      logic flush_ex;
      logic flush_m;
      logic flush_w;
   } pipe_ctrl_t;

   // Operand bypass select; the younger MEM result shadows WB
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] rd_m,
      input logic              we_m,
      input logic [REG_AW-1:0] rd_w,
      input logic              we_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (we_m && (rd_m != '0) && (rd_m == rs)) begin
         sel = FWD_MEM;
      end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding selects for both source operands.
module fwd_unit
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   input  logic [REG_AW-1:0] rd_addr_m_i,
   input  logic              reg_we_m_i,
   input  logic [REG_AW-1:0] rd_addr_w_i,
   input  logic              reg_we_w_i,
   output logic [1:0]        fwd_a_sel_o,
   output logic [1:0]        fwd_b_sel_o
);

   assign fwd_a_sel_o = fwd_sel(rs1_addr_i, rd_addr_m_i, reg_we_m_i, rd_addr_w_i, reg_we_w_i);
   assign fwd_b_sel_o = fwd_sel(rs2_addr_i, rd_addr_m_i, reg_we_m_i, rd_addr_w_i, reg_we_w_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: stalls/flushes, forwarding, multi-cycle
// and memory-wait sequencing, stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] rs1_addr_d,
   input  logic [REG_AW-1:0] rs2_addr_d,
   input  logic [REG_AW-1:0] rs1_addr_e,
   input  logic [REG_AW-1:0] rs2_addr_e,
   input  logic [REG_AW-1:0] rd_addr_e,
   input  logic [REG_AW-1:0] rd_addr_m,
   input  logic [REG_AW-1:0] rd_addr_w,
   input  logic              reg_we_e,
   input  logic              reg_we_m,
   input  logic              reg_we_w,
   input  logic              is_load_e,
   input  logic              branch_taken_e,
   input  logic              mc_op_e,
   input  logic              mc_done_i,
   input  logic              mem_req_m,
   input  logic              mem_ack_i,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_ex,
   output logic              flush_m,
   output logic              flush_w,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              mc_start_o,
   output logic              mc_err_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam int unsigned TMO_W = $clog2(MC_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MC_TIMEOUT);

   ctrl_state_e      state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             pend_q, pend_d;
   logic             armed_q;

   pipe_ctrl_t ctrl;
   logic       mc_start;
   logic       mem_stall;
   logic       load_use;

   fwd_unit u_fwd (
      .rs1_addr_i  (rs1_addr_e),
      .rs2_addr_i  (rs2_addr_e),
      .rd_addr_m_i (rd_addr_m),
      .reg_we_m_i  (reg_we_m),
      .rd_addr_w_i (rd_addr_w),
      .reg_we_w_i  (reg_we_w),
      .fwd_a_sel_o (fwd_a_sel),
      .fwd_b_sel_o (fwd_b_sel)
   );

   // Memory wait covers both the cycle the miss is seen and every un-acked wait cycle
   assign mem_stall = (state_q == CTRL_MEM_WAIT) ? ~mem_ack_i : (mem_req_m & ~mem_ack_i);

   assign load_use = is_load_e & reg_we_e & (rd_addr_e != '0) &
                     ((rd_addr_e == rs1_addr_d) | (rd_addr_e == rs2_addr_d));

   // Next-state and per-cycle control; nothing moves until the first edge after reset
   always_comb begin
      state_d  = state_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      pend_d   = pend_q;
      ctrl     = '0;
      mc_start = 1'b0;

      if (armed_q) begin
         if (mem_stall) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
            ctrl.flush_w = 1'b1;
            if (state_q != CTRL_MEM_WAIT) begin
               state_d = CTRL_MEM_WAIT;
               pend_d  = (state_q == CTRL_MC_BUSY);
            end
         end else begin
            unique case (state_q)
               CTRL_IDLE: begin
                  if (branch_taken_e) begin
                     ctrl.flush_d  = 1'b1;
                     ctrl.flush_ex = 1'b1;
                  end else if (mc_op_e) begin
                     mc_start = 1'b1;
                     state_d  = CTRL_MC_BUSY;
                     tmo_d    = '0;
                  end else if (load_use) begin
                     ctrl.stall_f  = 1'b1;
                     ctrl.stall_d  = 1'b1;
                     ctrl.flush_ex = 1'b1;
                  end
               end
               CTRL_MC_BUSY: begin
                  if (mc_done_i) begin
                     state_d = CTRL_IDLE;
                     tmo_d   = '0;
                  end else begin
                     ctrl.stall_f = 1'b1;
                     ctrl.stall_d = 1'b1;
                     ctrl.stall_e = 1'b1;
                     ctrl.flush_m = 1'b1;
                     if (tmo_q != TMO_MAX) begin
                        tmo_d = tmo_q + TMO_W'(1);
                     end
                     err_d = err_q | (tmo_d == TMO_MAX);
                  end
               end
               CTRL_MEM_WAIT: begin
                  // Ack cycle: MEM moves on, but a pending multi-cycle op still holds EX
                  pend_d = 1'b0;
                  if (pend_q) begin
                     ctrl.stall_f = 1'b1;
                     ctrl.stall_d = 1'b1;
                     ctrl.stall_e = 1'b1;
                     ctrl.flush_m = 1'b1;
                     state_d      = CTRL_MC_BUSY;
                  end else begin
                     state_d = CTRL_IDLE;
                  end
               end
               default: state_d = CTRL_IDLE;
            endcase
         end
      end

      cnt_d = cnt_q;
      if (ctrl.stall_f && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= CTRL_IDLE;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         armed_q <= 1'b1;
      end
   end

   assign stall_f     = ctrl.stall_f;
   assign stall_d     = ctrl.stall_d;
   assign stall_e     = ctrl.stall_e;
   assign stall_m     = ctrl.stall_m;
   assign flush_d     = ctrl.flush_d;
   assign flush_ex    = ctrl.flush_ex;
   assign flush_m     = ctrl.flush_m;
   assign flush_w     = ctrl.flush_w;
   assign mc_start_o  = mc_start;
   assign mc_err_o    = err_q;
   assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned T       = 4;
   localparam int unsigned CW      = 6;
   localparam int          CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_i;
   logic [4:0]    rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e;
   logic [4:0]    rd_addr_e, rd_addr_m, rd_addr_w;
   logic          reg_we_e, reg_we_m, reg_we_w;
   logic          is_load_e, branch_taken_e, mc_op_e, mc_done_i, mem_req_m, mem_ack_i;
   logic          stall_f, stall_d, stall_e, stall_m;
   logic          flush_d, flush_ex, flush_m, flush_w;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic          mc_start_o, mc_err_o;
   logic [CW-1:0] stall_cnt_o;

   pipe_hazard_ctrl #(.MC_TIMEOUT(T), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
      .rs1_addr_e(rs1_addr_e), .rs2_addr_e(rs2_addr_e),
      .rd_addr_e(rd_addr_e), .rd_addr_m(rd_addr_m), .rd_addr_w(rd_addr_w),
      .reg_we_e(reg_we_e), .reg_we_m(reg_we_m), .reg_we_w(reg_we_w),
      .is_load_e(is_load_e), .branch_taken_e(branch_taken_e),
      .mc_op_e(mc_op_e), .mc_done_i(mc_done_i),
      .mem_req_m(mem_req_m), .mem_ack_i(mem_ack_i),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_ex(flush_ex), .flush_m(flush_m), .flush_w(flush_w),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .mc_start_o(mc_start_o), .mc_err_o(mc_err_o), .stall_cnt_o(stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: what is outstanding, not how the controller encodes it
   bit m_armed, m_mc, m_mw, m_err;
   int m_busy, m_cnt;
   bit n_armed, n_mc, n_mw, n_err_st;
   int n_busy, n_cnt;
   logic [7:0] e_ctrl;
   logic       e_start;

   logic [7:0] last_ctrl;
   int obs_start, obs_stall_e, obs_stall_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (reg_we_m && rd_addr_m != 5'd0 && rd_addr_m == rs) return 2'b10;
      if (reg_we_w && rd_addr_w != 5'd0 && rd_addr_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_armed = 0; m_mc = 0; m_mw = 0; m_err = 0; m_busy = 0; m_cnt = 0;
   endtask

   task automatic model_eval();
      bit mem_stall, lu;
      n_armed = m_armed; n_mc = m_mc; n_mw = m_mw; n_err_st = m_err;
      n_busy = m_busy; n_cnt = m_cnt;
      e_ctrl = 8'h00; e_start = 1'b0;
      lu = is_load_e && reg_we_e && rd_addr_e != 5'd0 &&
           (rd_addr_e == rs1_addr_d || rd_addr_e == rs2_addr_d);
      mem_stall = m_mw ? !mem_ack_i : (mem_req_m && !mem_ack_i);
      if (!m_armed) begin
         n_armed = 1;
      end else if (mem_stall) begin
         e_ctrl = 8'b1111_0001;
         n_mw   = 1;
      end else if (m_mw) begin
         n_mw = 0;
         if (m_mc) e_ctrl = 8'b1110_0010;
      end else if (m_mc) begin
         if (mc_done_i) begin
            n_mc = 0;
         end else begin
            e_ctrl = 8'b1110_0010;
            n_busy = (m_busy + 1 > int'(T)) ? int'(T) : m_busy + 1;
            if (n_busy >= int'(T)) n_err_st = 1;
         end
      end else if (branch_taken_e) begin
         e_ctrl = 8'b0000_1100;
      end else if (mc_op_e) begin
         e_start = 1'b1;
         n_mc    = 1;
         n_busy  = 0;
      end else if (lu) begin
         e_ctrl = 8'b1100_0100;
      end
      if (e_ctrl[7] && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
   endtask

   task automatic clear_inputs();
      rs1_addr_d = 0; rs2_addr_d = 0; rs1_addr_e = 0; rs2_addr_e = 0;
      rd_addr_e = 0; rd_addr_m = 0; rd_addr_w = 0;
      reg_we_e = 0; reg_we_m = 0; reg_we_w = 0;
      is_load_e = 0; branch_taken_e = 0; mc_op_e = 0; mc_done_i = 0;
      mem_req_m = 0; mem_ack_i = 0;
   endtask

   task automatic rand_inputs();
      rs1_addr_d = 5'($urandom_range(0, 3)); rs2_addr_d = 5'($urandom_range(0, 3));
      rs1_addr_e = 5'($urandom_range(0, 3)); rs2_addr_e = 5'($urandom_range(0, 3));
      rd_addr_e  = 5'($urandom_range(0, 3)); rd_addr_m  = 5'($urandom_range(0, 3));
      rd_addr_w  = 5'($urandom_range(0, 3));
      reg_we_e = 1'($urandom_range(0, 1)); reg_we_m = 1'($urandom_range(0, 1));
      reg_we_w = 1'($urandom_range(0, 1));
      is_load_e      = ($urandom_range(0, 99) < 30);
      branch_taken_e = ($urandom_range(0, 99) < 15);
      mc_op_e        = ($urandom_range(0, 99) < 20);
      mc_done_i      = ($urandom_range(0, 99) < 25);
      mem_req_m      = ($urandom_range(0, 99) < 15);
      mem_ack_i      = ($urandom_range(0, 99) < 50);
   endtask

   // Compare one cycle at the falling edge, then commit the model on the rising edge
   task automatic cycle_check();
      @(negedge clk);
      model_eval();
      last_ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_ex, flush_m, flush_w};
      check("fwd_a", 32'(fwd_a_sel), 32'(exp_fwd(rs1_addr_e)));
      check("fwd_b", 32'(fwd_b_sel), 32'(exp_fwd(rs2_addr_e)));
      check("ctrl", 32'(last_ctrl), 32'(e_ctrl));
      check("mc_start", 32'(mc_start_o), 32'(e_start));
      check("mc_err", 32'(mc_err_o), 32'(m_err));
      check("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
      obs_start   += int'(mc_start_o);
      obs_stall_e += int'(stall_e);
      obs_stall_m += int'(stall_m);
      @(posedge clk);
      m_armed = n_armed; m_mc = n_mc; m_mw = n_mw; m_err = n_err_st;
      m_busy = n_busy; m_cnt = n_cnt;
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_cnt", 32'(stall_cnt_o), 32'd0);
      check("rst_err", 32'(mc_err_o), 32'd0);
      rst_i = 1'b1;
      cycle_check();
   endtask

   initial begin
      rst_i = 1'b0;
      clear_inputs();
      model_reset();
      do_reset();

      // Forwarding: MEM beats WB; x0 never forwards
      rd_addr_m = 5; reg_we_m = 1; rs1_addr_e = 5; rd_addr_w = 5; reg_we_w = 1;
      cycle_check();
      check("t1_mem_wins", 32'(fwd_a_sel), 32'(2'b10));
      rd_addr_m = 0; rd_addr_w = 0; rs1_addr_e = 0;
      cycle_check();
      check("t1_x0", 32'(fwd_a_sel), 32'(2'b00));
      clear_inputs();

      // Load-use, then load-use shadowed by a taken branch
      is_load_e = 1; reg_we_e = 1; rd_addr_e = 7; rs2_addr_d = 7;
      cycle_check();
      check("t2_lu", 32'(last_ctrl), 32'(8'b1100_0100));
      clear_inputs();
      cycle_check();
      check("t2_lu_gone", 32'(last_ctrl), 32'(8'b0000_0000));
      is_load_e = 1; reg_we_e = 1; rd_addr_e = 7; rs2_addr_d = 7; branch_taken_e = 1;
      cycle_check();
      check("t2_br", 32'(last_ctrl), 32'(8'b0000_1100));
      clear_inputs();

      // Multi-cycle op finishing after 10 busy cycles
      do_reset();
      obs_start = 0; obs_stall_e = 0;
      mc_op_e = 1;
      cycle_check();
      for (int i = 0; i < 10; i++) cycle_check();
      mc_done_i = 1;
      cycle_check();
      clear_inputs();
      cycle_check();
      check("t3_starts", 32'(obs_start), 32'd1);
      check("t3_stall_e", 32'(obs_stall_e), 32'd10);
      check("t3_cnt", 32'(stall_cnt_o), 32'd10);

      // Memory wait inside MC_BUSY keeps the timeout count
      do_reset();
      obs_stall_m = 0;
      mc_op_e = 1;
      cycle_check();
      repeat (2) cycle_check();
      mem_req_m = 1;
      repeat (3) cycle_check();
      mem_ack_i = 1;
      cycle_check();
      check("t4_resume", 32'(last_ctrl), 32'(8'b1110_0010));
      mem_req_m = 0; mem_ack_i = 0;
      cycle_check();
      check("t4_err_early", 32'(mc_err_o), 32'd0);
      cycle_check();
      check("t4_tmo_kept", 32'(mc_err_o), 32'd1);
      check("t4_stall_m", 32'(obs_stall_m), 32'd3);
      mc_done_i = 1;
      cycle_check();
      clear_inputs();
      cycle_check();

      // Timeout flag is sticky
      do_reset();
      mc_op_e = 1;
      cycle_check();
      repeat (3) cycle_check();
      check("t5_not_yet", 32'(mc_err_o), 32'd0);
      cycle_check();
      check("t5_err", 32'(mc_err_o), 32'd1);
      repeat (3) cycle_check();
      mc_done_i = 1;
      cycle_check();
      clear_inputs();
      repeat (2) cycle_check();
      check("t5_sticky", 32'(mc_err_o), 32'd1);

      // Asynchronous reset in the middle of a memory wait
      do_reset();
      mem_req_m = 1;
      repeat (2) cycle_check();
      #2;
      check("t6_pre", 32'(stall_m), 32'd1);
      rst_i = 1'b0;
      #1;
      check("t6_ctrl", 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_ex, flush_m, flush_w}), 32'd0);
      check("t6_start", 32'(mc_start_o), 32'd0);
      check("t6_cnt", 32'(stall_cnt_o), 32'd0);
      model_reset();
      clear_inputs();
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      repeat (3) cycle_check();

      // Random traffic, several reset epochs so the stall counter saturates and restarts
      for (int p = 0; p < 4; p++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            rand_inputs();
            cycle_check();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
